// File: rtl/fnd_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller:
// scan states, active-low font glyphs and default timing.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        SHOW = 2'd2
    } scan_state_t;

    localparam int SCAN_DIV_DEFAULT     = 100000;
    localparam int BLANK_CYCLES_DEFAULT = 1000;

    // Glyphs are {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
    localparam logic [7:0] FONT_0     = 8'hC0;
    localparam logic [7:0] FONT_1     = 8'hF9;
    localparam logic [7:0] FONT_2     = 8'hA4;
    localparam logic [7:0] FONT_3     = 8'hB0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hF8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_A     = 8'h88;
    localparam logic [7:0] FONT_B     = 8'h83;
    localparam logic [7:0] FONT_C     = 8'hC6;
    localparam logic [7:0] FONT_D     = 8'hA1;
    localparam logic [7:0] FONT_E     = 8'h86;
    localparam logic [7:0] FONT_F     = 8'h8E;
    localparam logic [7:0] FONT_BLANK = 8'hFF;

    function automatic logic [7:0] font_lookup(input logic [3:0] code);
        case (code)
            4'h0:    font_lookup = FONT_0;
            4'h1:    font_lookup = FONT_1;
            4'h2:    font_lookup = FONT_2;
            4'h3:    font_lookup = FONT_3;
            4'h4:    font_lookup = FONT_4;
            4'h5:    font_lookup = FONT_5;
            4'h6:    font_lookup = FONT_6;
            4'h7:    font_lookup = FONT_7;
            4'h8:    font_lookup = FONT_8;
            4'h9:    font_lookup = FONT_9;
            4'hA:    font_lookup = FONT_A;
            4'hB:    font_lookup = FONT_B;
            4'hC:    font_lookup = FONT_C;
            4'hD:    font_lookup = FONT_D;
            4'hE:    font_lookup = FONT_E;
            default: font_lookup = FONT_F;
        endcase
    endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// Combinational glyph generator: hex code to active-low segments, with
// segment blanking and an independent decimal-point control.
module fnd_font_rom
    import fnd_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] font
);

    logic [7:0] glyph;

    always_comb begin
        glyph = font_lookup(code);
        // The decimal point survives segment blanking so 0.0-style values still show it.
        font  = {~dp, blank ? FONT_BLANK[6:0] : glyph[6:0]};
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan of four seven-segment digits with per-period dead
// time, leading-zero blanking and tear-free registered font output.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [15:0] i_digits,
    input  logic [3:0]  i_dp,
    input  logic        i_lzb,
    output logic [1:0]  o_digitPosition,
    output logic        o_blank,
    output logic [7:0]  o_font,
    output logic        o_scan_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] COUNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM  = CW'(BLANK_CYCLES);

    generate
        if (BLANK_CYCLES >= SCAN_DIV || SCAN_DIV < 2 || BLANK_CYCLES < 0) begin : g_bad_params
            $error("fnd_scan_controller: need SCAN_DIV >= 2 and 0 <= BLANK_CYCLES < SCAN_DIV");
        end
    endgenerate

    scan_state_t   state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [1:0]    pos_reg,   pos_next;
    logic          blank_reg, blank_next;
    logic [7:0]    font_reg,  font_next;
    logic          tick_reg,  tick_next;
    logic          load_font;
    logic          clear_font;

    logic [3:0] is_zero;
    logic [3:0] lead_zero;
    logic [3:0] code_sel;
    logic [7:0] rom_font;

    // lead_zero[n] means digit n and every digit above it are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lzb
            assign is_zero[gi] = (i_digits[gi*4 +: 4] == 4'h0);
            if (gi == 0) begin : g_units
                assign lead_zero[gi] = 1'b0;
            end else if (gi == 3) begin : g_top
                assign lead_zero[gi] = is_zero[gi];
            end else begin : g_mid
                assign lead_zero[gi] = is_zero[gi] & lead_zero[gi+1];
            end
        end
    endgenerate

    assign code_sel = i_digits[{pos_next, 2'b00} +: 4];

    fnd_font_rom u_font_rom (
        .code  (code_sel),
        .blank (i_lzb & lead_zero[pos_next]),
        .dp    (i_dp[pos_next]),
        .font  (rom_font)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        pos_next   = pos_reg;
        tick_next  = 1'b0;
        load_font  = 1'b0;
        clear_font = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_en) begin
                    state_next = (BLANK_CYCLES == 0) ? SHOW : GAP;
                    load_font  = 1'b1;
                end
            end
            default: begin
                if (!i_en) begin
                    state_next = IDLE;
                    count_next = '0;
                    pos_next   = 2'd0;
                    clear_font = 1'b1;
                end else begin
                    if (count_reg == COUNT_LAST) begin
                        count_next = '0;
                        pos_next   = pos_reg + 2'd1;
                        tick_next  = 1'b1;
                        load_font  = 1'b1;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                    state_next = (count_next < BLANK_LIM) ? GAP : SHOW;
                end
            end
        endcase
        blank_next = (state_next != SHOW);
    end

    always_comb begin
        font_next = font_reg;
        if (clear_font) begin
            font_next = FONT_BLANK;
        end else if (load_font) begin
            font_next = rom_font;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            pos_reg   <= 2'd0;
            blank_reg <= 1'b1;
            font_reg  <= FONT_BLANK;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            pos_reg   <= pos_next;
            blank_reg <= blank_next;
            font_reg  <= font_next;
            tick_reg  <= tick_next;
        end
    end

    assign o_digitPosition = pos_reg;
    assign o_blank         = blank_reg;
    assign o_font          = font_reg;
    assign o_scan_tick     = tick_reg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for the scan controller at SCAN_DIV=8, with a second
// instance built without dead time.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lzb;

    logic [1:0]  pos,   pos0;
    logic        blank, blank0;
    logic [7:0]  font,  font0;
    logic        tick,  tick0;

    int total = 0;
    int bad   = 0;

    logic [9:0] sb_q[$];

    always #5 clk = ~clk;

    fnd_scan_controller #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_en            (en),
        .i_digits        (digits),
        .i_dp            (dp),
        .i_lzb           (lzb),
        .o_digitPosition (pos),
        .o_blank         (blank),
        .o_font          (font),
        .o_scan_tick     (tick)
    );

    fnd_scan_controller #(.SCAN_DIV(8), .BLANK_CYCLES(0)) dut_nogap (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_en            (en),
        .i_digits        (digits),
        .i_dp            (dp),
        .i_lzb           (lzb),
        .o_digitPosition (pos0),
        .o_blank         (blank0),
        .o_font          (font0),
        .o_scan_tick     (tick0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each position advance is one transaction against the scoreboard.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("tick_unexpected", 32'(tick), 32'd0);
            end else begin
                logic [9:0] item;
                item = sb_q.pop_front();
                $display("tick pos=%0d font=%02h (exp pos=%0d font=%02h)", pos, font, item[9:8], item[7:0]);
                check("tick_pos", 32'(pos), 32'(item[9:8]));
                check("tick_font", 32'(font), 32'(item[7:0]));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        digits = 16'h1234;
        dp     = 4'b0000;
        lzb    = 1'b0;

        @(negedge clk);
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_font", 32'(font), 32'hFF);
        check("rst_tick", 32'(tick), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("idle_blank", 32'(blank), 32'd1);
        check("idle_font", 32'(font), 32'hFF);

        // Plain scan of 1234.
        en = 1'b1;
        sb_q.push_back({2'd1, 8'hB0});
        sb_q.push_back({2'd2, 8'hA4});
        sb_q.push_back({2'd3, 8'hF9});
        sb_q.push_back({2'd0, 8'h99});
        @(negedge clk);
        check("start_pos", 32'(pos), 32'd0);
        check("start_font", 32'(font), 32'h99);
        for (int k = 0; k <= 32; k++) begin
            check("p1_blank", 32'(blank), ((k % 8) < 2) ? 32'd1 : 32'd0);
            check("p1_tick", 32'(tick), ((k % 8) == 0 && k > 0) ? 32'd1 : 32'd0);
            check("nogap_blank", 32'(blank0), 32'd0);
            @(negedge clk);
        end

        // Leading-zero blanking with a decimal point on a blanked digit.
        digits = 16'h0007;
        lzb    = 1'b1;
        dp     = 4'b0100;
        sb_q.push_back({2'd1, 8'hFF});
        sb_q.push_back({2'd2, 8'h7F});
        sb_q.push_back({2'd3, 8'hFF});
        sb_q.push_back({2'd0, 8'hF8});
        repeat (32) @(negedge clk);

        // Mid-period input change must not tear the displayed glyph.
        digits = 16'h1111;
        lzb    = 1'b0;
        dp     = 4'b0000;
        sb_q.push_back({2'd1, 8'hF9});
        repeat (11) @(negedge clk);
        digits = 16'h2222;
        sb_q.push_back({2'd2, 8'hA4});
        for (int i = 0; i < 4; i++) begin
            check("no_tear_font", 32'(font), 32'hF9);
            @(negedge clk);
        end
        check("after_edge_font", 32'(font), 32'hA4);
        repeat (5) @(negedge clk);
        check("pre_drop_pos", 32'(pos), 32'd2);

        // Disable mid-period, then restart.
        en = 1'b0;
        @(negedge clk);
        check("drop_pos", 32'(pos), 32'd0);
        check("drop_blank", 32'(blank), 32'd1);
        check("drop_font", 32'(font), 32'hFF);
        check("drop_tick", 32'(tick), 32'd0);
        @(negedge clk);
        check("idle_hold_font", 32'(font), 32'hFF);
        en = 1'b1;
        sb_q.push_back({2'd1, 8'hA4});
        @(negedge clk);
        check("restart_pos", 32'(pos), 32'd0);
        check("restart_tick", 32'(tick), 32'd0);
        check("restart_blank", 32'(blank), 32'd1);
        check("restart_font", 32'(font), 32'hA4);
        repeat (11) @(negedge clk);
        check("show_blank", 32'(blank), 32'd0);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("arst_pos", 32'(pos), 32'd0);
        check("arst_blank", 32'(blank), 32'd1);
        check("arst_font", 32'(font), 32'hFF);
        check("arst_tick", 32'(tick), 32'd0);
        sb_q.push_back({2'd1, 8'hA4});
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving clock cycles per digit period (1 kHz per digit at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, giving dead-time cycles at the start of each digit period.
REQ-003 SHALL have port i_clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_en  input  1  scan enable.
REQ-006 SHALL have port i_digits  input  16  four 4-bit codes; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 SHALL have port i_dp  input  4  decimal-point request per digit; bit n maps to digit n, 1 = lit.
REQ-008 SHALL have port i_lzb  input  1  leading-zero blanking enable.
REQ-009 SHALL have port o_digitPosition  output  2  current scan position; it drives the 2x4 digit-select decoder.
REQ-010 SHALL have port o_blank  output  1  1 = all digits must be off; the integrator gates the decoder output with it.
REQ-011 SHALL have port o_font  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-012 SHALL have port o_scan_tick  output  1  one-cycle pulse when the position advances.

Function
REQ-013 SHALL implement FSM states IDLE, GAP and SHOW.
REQ-014 In IDLE, the block SHALL hold o_blank=1, o_font=8'hFF, o_digitPosition=0 and period counter=0.
REQ-015 IDLE->GAP SHALL occur on the first edge with i_en=1; o_scan_tick SHALL stay 0 on this transition.
REQ-016 The period counter SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-017 o_blank SHALL be 1 while the counter is below BLANK_CYCLES (GAP) and 0 otherwise (SHOW).
REQ-018 With BLANK_CYCLES=0, GAP SHALL be skipped and the block SHALL enter SHOW directly.
REQ-019 On the edge where the counter goes from SCAN_DIV-1 to 0, o_digitPosition SHALL increment and wrap from 3 to 0.
REQ-020 o_scan_tick SHALL be 1 for exactly the cycle in which the new position first appears.
REQ-021 o_font SHALL be registered and SHALL change only on the same edge as o_digitPosition (and on IDLE exit), using i_digits/i_dp/i_lzb sampled at that edge; no mid-period tearing.
REQ-022 Font codes, with dp bit=1 (off), SHALL be: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
REQ-023 Leading-zero blanking: with i_lzb=1, digit n (n=3..1) SHALL show segments g..a off when its code and every higher code equal 0.
REQ-024 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-025 The dp bit SHALL be 0 (lit) whenever i_dp[n]=1, including on a digit blanked by leading-zero blanking.
REQ-026 i_en=0 in GAP or SHOW SHALL return the block to IDLE on the next edge (blank=1, position=0, counter=0, no tick).
REQ-027 BLANK_CYCLES >= SCAN_DIV or SCAN_DIV < 2 SHALL be rejected at elaboration.
REQ-028 The counter width SHALL be $clog2(SCAN_DIV); there SHALL be no overflow beyond the SCAN_DIV-1 wrap.

Reset
REQ-029 i_reset=1 SHALL immediately, without a clock, force state=IDLE, counter=0, o_digitPosition=0, o_blank=1, o_font=8'hFF and o_scan_tick=0.
REQ-030 After reset release, the block SHALL follow REQ-015; reset asserted mid-period SHALL abort the period with no tick.

Structure
REQ-031 Package fnd_pkg SHALL hold the state enum, the 16 font constants, FONT_BLANK=8'hFF and the default SCAN_DIV/BLANK_CYCLES values.
REQ-032 Sub-module fnd_font_rom (4-bit code plus blank plus dp in, 8-bit font out, combinational) SHALL be instantiated once.

Verification (SCAN_DIV=8, BLANK_CYCLES=2)
REQ-033 Reset then i_en=1, i_digits=16'h1234, i_lzb=0 -> position sequence 0,1,2,3,0 every 8 cycles; fonts 99,B0,A4,F9; o_blank high for the first 2 cycles of each period; tick every 8 cycles.
REQ-034 i_digits=16'h0007, i_lzb=1, i_dp=4'b0100 -> digit 3 FF, digit 2 7F, digit 1 FF, digit 0 F8.
REQ-035 i_digits changes from 16'h1111 to 16'h2222 at counter=4 -> o_font stays F9 until the next position edge, then shows A4.
REQ-036 i_en dropped at counter=5 in position 2 -> next cycle position 0, blank 1, font FF, no tick; i_en re-raised -> restart at position 0 without a tick.
REQ-037 i_reset pulsed asynchronously mid-SHOW -> outputs reach their reset values before the next clock edge.
REQ-038 BLANK_CYCLES=0 build -> o_blank stays 0 throughout scanning.
